// File: rtl/mem_store_buffer.sv
// In-order store buffer between the MEM stage and the data memory.
// It drains one store per cycle when no load needs the port, and it stalls loads that hit a buffered word.
module mem_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [3:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        dm_en,
    output logic [3:0]  dm_op,
    output logic [31:0] dm_add,
    output logic [31:0] dm_in,
    output logic [31:0] dm_pc,
    output logic        empty
);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t CountFull = cnt_t'(DEPTH);

    logic [3:0]  op_q   [DEPTH];
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;

    logic       push;
    logic       pop;
    logic       ld_hit;
    logic       load_owns;
    logic [3:0] st_op_norm;

    // Unknown width codes are stored as a word write.
    always_comb begin
        st_op_norm = 4'd0;
        if (st_op == 4'd1 || st_op == 4'd2) begin
            st_op_norm = st_op;
        end
    end

    assign empty    = (count_q == '0);
    assign st_ready = (count_q != CountFull);
    assign push     = st_valid && st_ready;

    // An entry is live when its distance from head is below count.
    always_comb begin
        ld_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ({1'b0, ptr_t'(ptr_t'(i) - head_q)} < count_q &&
                addr_q[i][31:2] == ld_addr[31:2]) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign ld_conflict = ld_valid && ld_hit;
    assign load_owns   = ld_valid && !ld_conflict;
    assign pop         = dm_en;

    always_comb begin
        dm_en  = !reset && !empty && !load_owns;
        dm_op  = 4'd0;
        dm_add = ld_addr;
        dm_in  = 32'd0;
        dm_pc  = 32'd0;
        if (dm_en) begin
            dm_op  = op_q[head_q];
            dm_add = addr_q[head_q];
            dm_in  = data_q[head_q];
            dm_pc  = pc_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + ptr_t'(1);
        end
        if (push) begin
            tail_d = tail_q + ptr_t'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                op_q[tail_q]   <= st_op_norm;
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
                pc_q[tail_q]   <= st_pc;
            end
        end
    end

endmodule
